// File: rtl/bus_pkg.sv
// Shared bus definitions: widths, access-type encodings and agent counts
// used by the arbiter, the muxes and the address decoder.
package bus_pkg;

  localparam int BUS_ADDR_WIDTH  = 30;
  localparam int BUS_DATA_WIDTH  = 32;
  localparam int OWNER_WIDTH     = 2;
  localparam int SLAVE_IDX_WIDTH = 3;
  localparam int NUM_MASTERS     = 4;
  localparam int NUM_SLAVES      = 8;

  localparam logic ACCESS_READ  = 1'b1;
  localparam logic ACCESS_WRITE = 1'b0;

endpackage

// File: rtl/bus_addr_dec.sv
// Turns the top address bits into one chip select per equal-sized slave
// region; deliberately ignores the address strobe.
module bus_addr_dec
  import bus_pkg::*;
(
  input  logic [SLAVE_IDX_WIDTH-1:0] slave_index,
  output logic [NUM_SLAVES-1:0]      cs
);

  assign cs = NUM_SLAVES'(1) << slave_index;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: holds the owner register and decodes it into
// one-hot grants. The owner keeps the bus until it drops its request.
module bus_arbiter
  import bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [OWNER_WIDTH-1:0] owner,
  output logic [NUM_MASTERS-1:0] grnt
);

  logic [OWNER_WIDTH-1:0] owner_next;
  logic [OWNER_WIDTH-1:0] cand;

  // Scan from the farthest candidate back to owner+1 so the nearest
  // requester in rotation order wins.
  always_comb begin
    owner_next = owner;
    cand       = owner;
    if (!req[owner]) begin
      for (int i = NUM_MASTERS - 1; i >= 1; i--) begin
        cand = owner + OWNER_WIDTH'(i);
        if (req[cand]) owner_next = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) owner <= '0;
    else      owner <= owner_next;
  end

  assign grnt = NUM_MASTERS'(1) << owner;

endmodule

// File: rtl/bus_master_mux.sv
// Forwards the bus owner's strobe, address, access type and write data to
// the shared slave-side signals.
module bus_master_mux
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
  input  logic [OWNER_WIDTH-1:0]            owner,
  input  logic [NUM_MASTERS-1:0]            as,
  input  logic [NUM_MASTERS-1:0]            wr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wr_data,
  output logic                              slave_as,
  output logic [ADDR_WIDTH-1:0]             slave_addr,
  output logic                              slave_wr,
  output logic [DATA_WIDTH-1:0]             slave_wr_data
);

  always_comb begin
    slave_as      = 1'b0;
    slave_addr    = '0;
    slave_wr      = ACCESS_READ;
    slave_wr_data = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (owner == OWNER_WIDTH'(m)) begin
        slave_as      = as[m];
        slave_addr    = addr[m*ADDR_WIDTH +: ADDR_WIDTH];
        slave_wr      = wr[m];
        slave_wr_data = wr_data[m*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/bus_slave_mux.sv
// Returns ready and read data from the selected slave; with no chip select
// active both fall back to zero.
module bus_slave_mux
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
  input  logic [NUM_SLAVES-1:0]            cs,
  input  logic [NUM_SLAVES-1:0]            rdy,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] out_data,
  output logic                             master_rdy,
  output logic [DATA_WIDTH-1:0]            master_data
);

  always_comb begin
    master_rdy  = 1'b0;
    master_data = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (cs[s]) begin
        master_rdy  = rdy[s];
        master_data = out_data[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/bus_top.sv
// Four-master, eight-slave shared bus: wires the arbiter, master mux,
// address decoder and slave mux together. Only the arbiter holds state.
module bus_top
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  master_0_req,
  input  logic                  master_0_as,
  input  logic [ADDR_WIDTH-1:0] master_0_addr,
  input  logic                  master_0_wr,
  input  logic [DATA_WIDTH-1:0] master_0_wr_data,
  output logic                  master_0_grnt,
  input  logic                  master_1_req,
  input  logic                  master_1_as,
  input  logic [ADDR_WIDTH-1:0] master_1_addr,
  input  logic                  master_1_wr,
  input  logic [DATA_WIDTH-1:0] master_1_wr_data,
  output logic                  master_1_grnt,
  input  logic                  master_2_req,
  input  logic                  master_2_as,
  input  logic [ADDR_WIDTH-1:0] master_2_addr,
  input  logic                  master_2_wr,
  input  logic [DATA_WIDTH-1:0] master_2_wr_data,
  output logic                  master_2_grnt,
  input  logic                  master_3_req,
  input  logic                  master_3_as,
  input  logic [ADDR_WIDTH-1:0] master_3_addr,
  input  logic                  master_3_wr,
  input  logic [DATA_WIDTH-1:0] master_3_wr_data,
  output logic                  master_3_grnt,
  output logic                  slave_as,
  output logic [ADDR_WIDTH-1:0] slave_addr,
  output logic                  slave_wr,
  output logic [DATA_WIDTH-1:0] slave_wr_data,
  output logic                  slave_0_cs,
  output logic                  slave_1_cs,
  output logic                  slave_2_cs,
  output logic                  slave_3_cs,
  output logic                  slave_4_cs,
  output logic                  slave_5_cs,
  output logic                  slave_6_cs,
  output logic                  slave_7_cs,
  input  logic                  slave_0_rdy,
  input  logic                  slave_1_rdy,
  input  logic                  slave_2_rdy,
  input  logic                  slave_3_rdy,
  input  logic                  slave_4_rdy,
  input  logic                  slave_5_rdy,
  input  logic                  slave_6_rdy,
  input  logic                  slave_7_rdy,
  input  logic [DATA_WIDTH-1:0] slave_0_out_data,
  input  logic [DATA_WIDTH-1:0] slave_1_out_data,
  input  logic [DATA_WIDTH-1:0] slave_2_out_data,
  input  logic [DATA_WIDTH-1:0] slave_3_out_data,
  input  logic [DATA_WIDTH-1:0] slave_4_out_data,
  input  logic [DATA_WIDTH-1:0] slave_5_out_data,
  input  logic [DATA_WIDTH-1:0] slave_6_out_data,
  input  logic [DATA_WIDTH-1:0] slave_7_out_data,
  output logic                  master_rdy,
  output logic [DATA_WIDTH-1:0] master_data
);

  logic [OWNER_WIDTH-1:0] owner;
  logic [NUM_MASTERS-1:0] grnt;
  logic [NUM_SLAVES-1:0]  cs;

  bus_arbiter u_arbiter (
    .clk   (clk),
    .rst_  (rst_),
    .req   ({master_3_req, master_2_req, master_1_req, master_0_req}),
    .owner (owner),
    .grnt  (grnt)
  );

  assign {master_3_grnt, master_2_grnt, master_1_grnt, master_0_grnt} = grnt;

  bus_master_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_master_mux (
    .owner         (owner),
    .as            ({master_3_as, master_2_as, master_1_as, master_0_as}),
    .wr            ({master_3_wr, master_2_wr, master_1_wr, master_0_wr}),
    .addr          ({master_3_addr, master_2_addr, master_1_addr, master_0_addr}),
    .wr_data       ({master_3_wr_data, master_2_wr_data, master_1_wr_data, master_0_wr_data}),
    .slave_as      (slave_as),
    .slave_addr    (slave_addr),
    .slave_wr      (slave_wr),
    .slave_wr_data (slave_wr_data)
  );

  bus_addr_dec u_addr_dec (
    .slave_index (slave_addr[ADDR_WIDTH-1 -: SLAVE_IDX_WIDTH]),
    .cs          (cs)
  );

  assign {slave_7_cs, slave_6_cs, slave_5_cs, slave_4_cs,
          slave_3_cs, slave_2_cs, slave_1_cs, slave_0_cs} = cs;

  bus_slave_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_slave_mux (
    .cs          (cs),
    .rdy         ({slave_7_rdy, slave_6_rdy, slave_5_rdy, slave_4_rdy,
                   slave_3_rdy, slave_2_rdy, slave_1_rdy, slave_0_rdy}),
    .out_data    ({slave_7_out_data, slave_6_out_data, slave_5_out_data, slave_4_out_data,
                   slave_3_out_data, slave_2_out_data, slave_1_out_data, slave_0_out_data}),
    .master_rdy  (master_rdy),
    .master_data (master_data)
  );

endmodule

// File: tb/tb_bus_top.sv
// Directed scoreboard bench for bus_top: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_bus_top;
  import bus_pkg::*;

  typedef struct {
    string       name;
    logic [3:0]  grnt;
    logic [7:0]  cs;
    logic        s_as;
    logic [29:0] s_addr;
    logic        s_wr;
    logic [31:0] s_wdata;
    logic        m_rdy;
    logic [31:0] m_data;
  } exp_t;

  logic        clk;
  logic        rst_;
  logic [3:0]  req;
  logic [3:0]  as;
  logic [3:0]  wr;
  logic [29:0] addr [4];
  logic [31:0] wdata [4];
  logic [7:0]  s_rdy;

  logic [3:0]  grnt;
  logic [7:0]  cs;
  logic        slave_as;
  logic [29:0] slave_addr;
  logic        slave_wr;
  logic [31:0] slave_wr_data;
  logic        master_rdy;
  logic [31:0] master_data;

  exp_t exp_q [$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  bus_top dut (
    .clk (clk), .rst_ (rst_),
    .master_0_req (req[0]), .master_0_as (as[0]), .master_0_addr (addr[0]),
    .master_0_wr (wr[0]), .master_0_wr_data (wdata[0]), .master_0_grnt (grnt[0]),
    .master_1_req (req[1]), .master_1_as (as[1]), .master_1_addr (addr[1]),
    .master_1_wr (wr[1]), .master_1_wr_data (wdata[1]), .master_1_grnt (grnt[1]),
    .master_2_req (req[2]), .master_2_as (as[2]), .master_2_addr (addr[2]),
    .master_2_wr (wr[2]), .master_2_wr_data (wdata[2]), .master_2_grnt (grnt[2]),
    .master_3_req (req[3]), .master_3_as (as[3]), .master_3_addr (addr[3]),
    .master_3_wr (wr[3]), .master_3_wr_data (wdata[3]), .master_3_grnt (grnt[3]),
    .slave_as (slave_as), .slave_addr (slave_addr), .slave_wr (slave_wr),
    .slave_wr_data (slave_wr_data),
    .slave_0_cs (cs[0]), .slave_1_cs (cs[1]), .slave_2_cs (cs[2]), .slave_3_cs (cs[3]),
    .slave_4_cs (cs[4]), .slave_5_cs (cs[5]), .slave_6_cs (cs[6]), .slave_7_cs (cs[7]),
    .slave_0_rdy (s_rdy[0]), .slave_1_rdy (s_rdy[1]), .slave_2_rdy (s_rdy[2]),
    .slave_3_rdy (s_rdy[3]), .slave_4_rdy (s_rdy[4]), .slave_5_rdy (s_rdy[5]),
    .slave_6_rdy (s_rdy[6]), .slave_7_rdy (s_rdy[7]),
    .slave_0_out_data (32'd0), .slave_1_out_data (32'd1), .slave_2_out_data (32'd2),
    .slave_3_out_data (32'd3), .slave_4_out_data (32'd4), .slave_5_out_data (32'd5),
    .slave_6_out_data (32'd6), .slave_7_out_data (32'd7),
    .master_rdy (master_rdy), .master_data (master_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mkExp(input string name, input logic [3:0] g, input logic [7:0] c,
                                 input logic a, input logic [29:0] ad, input logic w,
                                 input logic [31:0] wd, input logic r, input logic [31:0] d);
    exp_t e;
    e.name = name; e.grnt = g; e.cs = c; e.s_as = a; e.s_addr = ad;
    e.s_wr = w; e.s_wdata = wd; e.m_rdy = r; e.m_data = d;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drive a request pattern after the monitor's sample point, then queue
  // one expectation per rising edge that follows.
  task automatic applyStimulus(input string name, input logic [3:0] req_v, input int cycles, input exp_t e);
    @(negedge clk);
    #1;
    rst_ = 1'b0;
    req  = req_v;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      e.name = $sformatf("%s[%0d]", name, c);
      exp_q.push_back(e);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, ".grnt"},    64'(grnt),          64'(e.grnt));
        checkOutput({e.name, ".cs"},      64'(cs),            64'(e.cs));
        checkOutput({e.name, ".as"},      64'(slave_as),      64'(e.s_as));
        checkOutput({e.name, ".addr"},    64'(slave_addr),    64'(e.s_addr));
        checkOutput({e.name, ".wr"},      64'(slave_wr),      64'(e.s_wr));
        checkOutput({e.name, ".wr_data"}, 64'(slave_wr_data), 64'(e.s_wdata));
        checkOutput({e.name, ".rdy"},     64'(master_rdy),    64'(e.m_rdy));
        checkOutput({e.name, ".data"},    64'(master_data),   64'(e.m_data));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time %0t, limit 100000", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    rst_  = 1'b1;
    req   = 4'b0000;
    as    = 4'hF;
    wr    = {4{ACCESS_READ}};
    s_rdy = 8'hFF;
    for (int n = 0; n < 4; n++) begin
      addr[n]  = 30'(n) << 27;
      wdata[n] = 32'hA000_0000 | 32'(n);
    end

    #1;
    exp_q.push_back(mkExp("reset", 4'b0001, 8'h01, 1'b1, 30'h0, 1'b1, 32'hA000_0000, 1'b1, 32'd0));

    applyStimulus("grant_m1", 4'b1110, 1,
      mkExp("", 4'b0010, 8'h02, 1'b1, 30'h0800_0000, 1'b1, 32'hA000_0001, 1'b1, 32'd1));
    applyStimulus("grant_m2", 4'b1101, 1,
      mkExp("", 4'b0100, 8'h04, 1'b1, 30'h1000_0000, 1'b1, 32'hA000_0002, 1'b1, 32'd2));
    applyStimulus("grant_m3", 4'b1011, 1,
      mkExp("", 4'b1000, 8'h08, 1'b1, 30'h1800_0000, 1'b1, 32'hA000_0003, 1'b1, 32'd3));
    applyStimulus("wrap_m0", 4'b0111, 1,
      mkExp("", 4'b0001, 8'h01, 1'b1, 30'h0, 1'b1, 32'hA000_0000, 1'b1, 32'd0));
    applyStimulus("hold_owner", 4'b1111, 3,
      mkExp("", 4'b0001, 8'h01, 1'b1, 30'h0, 1'b1, 32'hA000_0000, 1'b1, 32'd0));
    applyStimulus("no_req", 4'b0000, 2,
      mkExp("", 4'b0001, 8'h01, 1'b1, 30'h0, 1'b1, 32'hA000_0000, 1'b1, 32'd0));

    @(negedge clk);
    #1;
    addr[2]  = 30'h3800_0000;
    wr[2]    = ACCESS_WRITE;
    wdata[2] = 32'hDEAD_BEEF;
    s_rdy[7] = 1'b0;
    applyStimulus("write_m2", 4'b0100, 2,
      mkExp("", 4'b0100, 8'h80, 1'b1, 30'h3800_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd7));

    @(negedge clk);
    #1;
    addr[2]  = 30'h1000_0000;
    wr[2]    = ACCESS_READ;
    wdata[2] = 32'hA000_0002;
    s_rdy[7] = 1'b1;
    as[3]    = 1'b0;
    applyStimulus("grant_m3_noas", 4'b1000, 1,
      mkExp("", 4'b1000, 8'h08, 1'b0, 30'h1800_0000, 1'b1, 32'hA000_0003, 1'b1, 32'd3));

    // Reset lands between edges; grant must move before the next rise.
    @(posedge clk);
    #2;
    rst_ = 1'b1;
    #1;
    exp_q.push_back(mkExp("mid_reset", 4'b0001, 8'h01, 1'b1, 30'h0, 1'b1, 32'hA000_0000, 1'b1, 32'd0));
    @(negedge clk);
    #1;

    applyStimulus("after_reset", 4'b0001, 2,
      mkExp("", 4'b0001, 8'h01, 1'b1, 30'h0, 1'b1, 32'hA000_0000, 1'b1, 32'd0));

    @(negedge clk);
    #1;
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/bus_top.md
BUS_TOP -- requirements
Module: bus_top

Interface
REQ-001 The block SHALL have these parameters: ADDR_WIDTH, default 30, word address width; DATA_WIDTH, default 32, data width.
REQ-002 The block SHALL use one clock, and its reset SHALL be asynchronous and active-high; the ports SHALL be clk and rst_.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_  in  1  asynchronous reset, active-high.
REQ-005 master_N_req  in  1  bus request from master N, N=0..3.
REQ-006 master_N_as  in  1  address strobe from master N.
REQ-007 master_N_addr  in  ADDR_WIDTH  word address from master N.
REQ-008 master_N_wr  in  1  access type from master N: READ=1, WRITE=0.
REQ-009 master_N_wr_data  in  DATA_WIDTH  write data from master N.
REQ-010 master_N_grnt  out  1  bus grant to master N.
REQ-011 slave_as, slave_addr, slave_wr, slave_wr_data  out  1/ADDR_WIDTH/1/DATA_WIDTH  muxed signals from the bus owner, common to all slaves.
REQ-012 slave_M_cs  out  1  chip select for slave M, M=0..7.
REQ-013 slave_M_rdy  in  1  ready from slave M.
REQ-014 slave_M_out_data  in  DATA_WIDTH  read data from slave M.
REQ-015 master_rdy, master_data  out  1/DATA_WIDTH  muxed ready and read data, common to all masters.

Function
REQ-016 The block SHALL hold a 2-bit owner register naming the master that owns the bus.
REQ-017 master_N_grnt SHALL be the combinational one-hot decode of owner; exactly one grant SHALL be high at all times.
REQ-018 If master_owner_req=1 on a rising edge, owner SHALL stay unchanged.
REQ-019 If master_owner_req=0 on a rising edge, the next owner SHALL be the first master with req=1 in the order owner+1, owner+2, owner+3 (mod 4).
REQ-020 If no master requests, owner SHALL stay unchanged.
REQ-021 A new grant SHALL be visible one cycle after the owner drops its request.
REQ-022 slave_as, slave_addr, slave_wr and slave_wr_data SHALL combinationally equal the owner's master_as, master_addr, master_wr and master_wr_data.
REQ-023 The slave index SHALL be slave_addr[ADDR_WIDTH-1:ADDR_WIDTH-3], giving 8 equal regions.
REQ-024 slave_M_cs SHALL be 1 exactly when the slave index equals M; the decode is combinational and independent of slave_as.
REQ-025 master_rdy and master_data SHALL combinationally equal slave_M_rdy and slave_M_out_data of the selected slave M.
REQ-026 If no cs is active (e.g. X address), master_rdy SHALL be 0 and master_data SHALL be 0.
REQ-027 The block SHALL have no latency other than the arbitration register.

Reset
REQ-028 While rst_=1, owner SHALL be 0 immediately, regardless of clk.
REQ-029 During reset, master_0_grnt SHALL be 1 and the other grants 0; all other outputs follow the combinational paths from master 0.
REQ-030 Reset asserted mid-transfer SHALL return ownership to master 0 with no state other than owner retained.

Structure
REQ-031 ADDR_WIDTH, DATA_WIDTH, READ/WRITE encodings and the 2-bit owner and 3-bit slave index widths SHALL live in a shared bus package.
REQ-032 Ownership SHALL be split into four sub-modules: bus_arbiter (owner register and grants), bus_master_mux, bus_addr_dec and bus_slave_mux; bus_top only wires them together.

Verification
REQ-033 Reset, then m0 req=0 and m1..m3 req=1 with addr[29:27]=001/010/011 -> after the edge master_1_grnt=1, slave_1_cs=1, slave_addr=0x0800_0000, master_data=1.
REQ-034 m1 req=0 with m0, m2, m3 req=1 -> owner=2, slave_2_cs=1, master_data=2; then m2 req=0 -> owner=3, master_data=3.
REQ-035 m3 req=0 with m0..m2 req=1 -> owner wraps to 0, slave_0_cs=1, master_data=0, master_rdy=1.
REQ-036 Owner keeps req=1 while others request -> grant unchanged for 3+ cycles; all req=0 -> grant unchanged.
REQ-037 Owner m2, WRITE with wr_data=0xDEADBEEF to addr 0x3800_0000 -> slave_7_cs=1, slave_wr=0, slave_wr_data=0xDEADBEEF; slave_7_rdy=0 -> master_rdy=0.
REQ-038 Assert rst_ mid-cycle while owner=3 -> master_0_grnt=1 immediately, before the next edge.
